bin_to_onehot_sel: RTL and testbench

Registered binary-to-one-hot select generator: the decode counterpart of the one-hot-to-binary encoder. It accepts a binary index over a valid/ready handshake and drives a one-hot select vector that is safe for downstream one-hot muxes. Every change of selection is break-before-make: the vector is forced to all-zero for a programmable number of cycles, so two bits are never high at once. It sits in front of one-hot selected mux banks, such as clock and functional muxes, in the SoC glue logic.

---
 rtl/bin_to_onehot_sel.sv | 118 +++++++++++
 tb/tb_bin_to_onehot_sel.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bin_to_onehot_sel.sv
// Registered binary-to-one-hot select generator with break-before-make switching.
// Every change of selection inserts GAP_CYCLES all-zero cycles so downstream one-hot muxes never see two bits high.
module bin_to_onehot_sel #(
    parameter int ONEHOT_WIDTH = 8,
    parameter int GAP_CYCLES   = 2,
    parameter int RESET_IDX    = 0,
    localparam int BIN_W       = $clog2(ONEHOT_WIDTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [BIN_W-1:0]        bin_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [ONEHOT_WIDTH-1:0] onehot_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int                CNT_W     = $clog2(GAP_CYCLES + 1);
    localparam int                IDX_RANGE = 2 ** BIN_W;
    localparam logic [BIN_W-1:0]  RESET_BIN = BIN_W'(RESET_IDX);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        MAKE
    } state_e;

    state_e               state_q, state_d;
    logic [BIN_W-1:0]     cur_q, cur_d;
    logic [BIN_W-1:0]     tgt_q, tgt_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [IDX_RANGE-1:0] legal_idx;
    logic                 accept;

    // Table lookup rather than a magnitude compare, which is constant when ONEHOT_WIDTH is a power of two.
    always_comb begin
        legal_idx = '0;
        for (int i = 0; i < IDX_RANGE; i++) begin
            legal_idx[i] = (i < ONEHOT_WIDTH);
        end
    end

    assign ready_o = (state_q != BREAK);
    assign accept  = valid_i && ready_o;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            BREAK: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = MAKE;
                    cur_d   = tgt_q;
                    done_d  = 1'b1;
                end
            end
            default: begin
                // MAKE behaves like IDLE so a new request can be taken in the completion cycle.
                state_d = IDLE;
                if (accept) begin
                    if (!legal_idx[bin_i]) begin
                        err_d = 1'b1;
                    end else if (bin_i == cur_q) begin
                        done_d = 1'b1;
                    end else begin
                        tgt_d   = bin_i;
                        cnt_d   = GAP_LOAD;
                        state_d = BREAK;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cur_q   <= RESET_BIN;
            tgt_q   <= RESET_BIN;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Decoded only from state and cur_q, so reset forces the reset selection without waiting for a clock.
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
            onehot_o[i] = (state_q != BREAK) && (cur_q == BIN_W'(i));
        end
    end

    assign done_o = done_q;
    assign err_o  = err_q;

    a_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(onehot_o));
    a_done_err_excl: assert property (@(posedge clk_i) disable iff (!rst_ni) !(done_o && err_o));

endmodule

// File: tb/tb_bin_to_onehot_sel.sv
// Scoreboard bench for bin_to_onehot_sel: an 8-wide and a 6-wide instance share one request stream.
// A behavioural model pushes each cycle's expected outputs when stimulus is driven; they are popped after the edge.
module tb_bin_to_onehot_sel;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rstN;
    logic [2:0] binIn;
    logic       validIn;

    logic       ready8, done8, err8;
    logic [7:0] onehot8;
    logic       ready6, done6, err6;
    logic [5:0] onehot6;

    typedef struct packed {
        logic [7:0] onehot;
        logic       ready;
        logic       done;
        logic       err;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    int   mW[2] = '{8, 6};
    int   mCur[2];
    int   mTgt[2];
    int   mGap[2];
    bit   mBusy[2];
    bit   mDone[2];
    bit   mErr[2];

    always #5 clk = ~clk;

    bin_to_onehot_sel #(.ONEHOT_WIDTH(8), .GAP_CYCLES(GAP), .RESET_IDX(0)) dut8 (
        .clk_i    (clk),
        .rst_ni   (rstN),
        .bin_i    (binIn),
        .valid_i  (validIn),
        .ready_o  (ready8),
        .onehot_o (onehot8),
        .done_o   (done8),
        .err_o    (err8)
    );

    bin_to_onehot_sel #(.ONEHOT_WIDTH(6), .GAP_CYCLES(GAP), .RESET_IDX(0)) dut6 (
        .clk_i    (clk),
        .rst_ni   (rstN),
        .bin_i    (binIn),
        .valid_i  (validIn),
        .ready_o  (ready6),
        .onehot_o (onehot6),
        .done_o   (done6),
        .err_o    (err6)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Model state: mGap counts zero cycles still to come after the current one.
    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mCur[i]  = 0;
            mTgt[i]  = 0;
            mGap[i]  = 0;
            mBusy[i] = 1'b0;
            mDone[i] = 1'b0;
            mErr[i]  = 1'b0;
        end
        sbQ.delete();
    endtask

    task automatic modelStep(input int i, input bit v, input int b);
        mDone[i] = 1'b0;
        mErr[i]  = 1'b0;
        if (mBusy[i]) begin
            if (mGap[i] > 0) begin
                mGap[i]--;
            end else begin
                mBusy[i] = 1'b0;
                mCur[i]  = mTgt[i];
                mDone[i] = 1'b1;
            end
        end else if (v) begin
            if (b >= mW[i]) begin
                mErr[i] = 1'b1;
            end else if (b == mCur[i]) begin
                mDone[i] = 1'b1;
            end else begin
                mBusy[i] = 1'b1;
                mTgt[i]  = b;
                mGap[i]  = GAP - 1;
            end
        end
    endtask

    function automatic exp_t modelExpect(input int i);
        exp_t e;
        e.onehot = mBusy[i] ? 8'h00 : 8'(1 << mCur[i]);
        e.ready  = !mBusy[i];
        e.done   = mDone[i];
        e.err    = mErr[i];
        return e;
    endfunction

    task automatic compareInst(input int i, input exp_t e, input string tag);
        logic [7:0] aOh;
        logic       aR, aD, aE;
        string      t;
        if (i == 0) begin
            aOh = onehot8; aR = ready8; aD = done8; aE = err8;
        end else begin
            aOh = {2'b00, onehot6}; aR = ready6; aD = done6; aE = err6;
        end
        t = $sformatf("%s/w%0d", tag, mW[i]);
        checkOutput({t, " onehot"}, 32'(aOh), 32'(e.onehot));
        checkOutput({t, " ready"}, 32'(aR), 32'(e.ready));
        checkOutput({t, " done"}, 32'(aD), 32'(e.done));
        checkOutput({t, " err"}, 32'(aE), 32'(e.err));
        checkOutput({t, " onehot0"}, 32'($onehot0(aOh)), 32'd1);
    endtask

    task automatic checkNow(input string tag);
        for (int i = 0; i < 2; i++) begin
            compareInst(i, modelExpect(i), tag);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [2:0] b, input string tag);
        exp_t e;
        validIn = v;
        binIn   = b;
        for (int i = 0; i < 2; i++) begin
            modelStep(i, v, int'(b));
            sbQ.push_back(modelExpect(i));
        end
        @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            e = sbQ.pop_front();
            compareInst(i, e, tag);
        end
    endtask

    initial begin
        rstN    = 1'b1;
        validIn = 1'b0;
        binIn   = 3'd0;
        modelReset();
        #1 rstN = 1'b0;
        #1 checkNow("async_reset");
        repeat (2) @(posedge clk);
        #2 rstN = 1'b1;
        #1 checkNow("reset_release");

        applyStimulus(1'b1, 3'd0, "same_idx0");
        applyStimulus(1'b0, 3'd0, "idle0");

        applyStimulus(1'b1, 3'd5, "sw5_accept");
        applyStimulus(1'b0, 3'd0, "sw5_gap");
        applyStimulus(1'b0, 3'd0, "sw5_make");
        applyStimulus(1'b0, 3'd0, "sw5_idle");

        applyStimulus(1'b1, 3'd7, "bin7");
        repeat (3) applyStimulus(1'b0, 3'd0, "bin7_after");

        applyStimulus(1'b1, 3'd3, "sw3");
        repeat (3) applyStimulus(1'b0, 3'd0, "sw3_after");

        repeat (3) applyStimulus(1'b1, 3'd2, "b2b_2");
        applyStimulus(1'b1, 3'd4, "b2b_4_in_make");
        repeat (4) applyStimulus(1'b0, 3'd0, "b2b_after");

        applyStimulus(1'b1, 3'd5, "pre_rst");
        #1 rstN = 1'b0;
        modelReset();
        #1 checkNow("rst_mid_break");
        #3 rstN = 1'b1;
        #1 checkNow("rst_mid_release");
        repeat (3) applyStimulus(1'b0, 3'd0, "post_rst");

        for (int n = 0; n < 60; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
